// File: rtl/ascii_flow_pkg.sv
// Shared types and helpers for the ASCII flow splitter: character classes,
// range constants, the buffered entry layout and the byte classifier.
package ascii_flow_pkg;

   typedef enum logic [2:0] {
      UPPER    = 3'd0,
      LOWER    = 3'd1,
      SPACE    = 3'd2,
      OTHER    = 3'd3,
      NONPRINT = 3'd4
   } ascii_cls_e;

   localparam logic [7:0] ASCII_UP_LO  = 8'h41;
   localparam logic [7:0] ASCII_UP_HI  = 8'h5A;
   localparam logic [7:0] ASCII_LO_LO  = 8'h61;
   localparam logic [7:0] ASCII_LO_HI  = 8'h7A;
   localparam logic [7:0] ASCII_SPACE  = 8'h20;
   localparam logic [7:0] ASCII_PRN_LO = 8'h21;
   localparam logic [7:0] ASCII_PRN_HI = 8'h7E;

   // Class is stored next to the byte so the read side never re-decodes ranges.
   typedef struct packed {
      ascii_cls_e cls;
      logic [7:0] ch;
   } ascii_ent_t;

   function automatic ascii_cls_e classify(input logic [7:0] b);
      if (b >= ASCII_UP_LO && b <= ASCII_UP_HI)       return UPPER;
      else if (b >= ASCII_LO_LO && b <= ASCII_LO_HI)  return LOWER;
      else if (b == ASCII_SPACE)                      return SPACE;
      else if (b >= ASCII_PRN_LO && b <= ASCII_PRN_HI) return OTHER;
      else                                            return NONPRINT;
   endfunction

endpackage

// File: rtl/ascii_sync_fifo.sv
// Synchronous FIFO; power-of-two DEPTH, naturally wrapping pointers and an
// occupancy counter one bit wider than the pointers for full/empty.
module ascii_sync_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] wdata,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty
);
   localparam int            AW       = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          do_push, do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: empty gates everything read from it.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/ascii_flow_splitter.sv
// Classifies incoming ASCII, buffers printable characters and splits the head
// into cap/low lanes. Define ASCII_SPLIT_DROP_OTHER_EN to drop punctuation too.
module ascii_flow_splitter
   import ascii_flow_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       cap_flow,
   output logic [7:0]       low_flow,
   output logic             is_space,
   output logic [CNT_W-1:0] char_cnt,
   output logic [CNT_W-1:0] drop_cnt
);
   localparam int EW = $bits(ascii_ent_t);

   ascii_cls_e  in_cls;
   ascii_ent_t  wr_ent, head;
   logic [EW-1:0] head_raw;
   logic        keep, accept, push, pop, drop, full, empty;

   assign in_cls = classify(in_data);

`ifdef ASCII_SPLIT_DROP_OTHER_EN
   assign keep = (in_cls == UPPER) || (in_cls == LOWER) || (in_cls == SPACE);
`else
   assign keep = (in_cls != NONPRINT);
`endif

   assign in_ready  = ~full;
   assign out_valid = ~empty;
   assign accept    = in_valid & in_ready;
   assign push      = accept & keep;
   assign drop      = accept & ~keep;
   assign pop       = out_valid & out_ready;

   assign wr_ent = '{cls: in_cls, ch: in_data};
   assign head   = ascii_ent_t'(head_raw);

   ascii_sync_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .wdata (wr_ent),
      .rdata (head_raw),
      .full  (full),
      .empty (empty)
   );

   always_comb begin
      cap_flow = '0;
      low_flow = '0;
      is_space = 1'b0;
      if (out_valid) begin
         case (head.cls)
            UPPER:   cap_flow = head.ch;
            LOWER:   low_flow = head.ch;
            SPACE:   is_space = 1'b1;
            default: ;
         endcase
      end
   end

   // Saturating event counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         char_cnt <= '0;
         drop_cnt <= '0;
      end else begin
         if (pop && char_cnt != '1)  char_cnt <= char_cnt + 1'b1;
         if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_ascii_flow_splitter.sv
// Directed bench for ascii_flow_splitter; expectations follow the
// ASCII_SPLIT_DROP_OTHER_EN setting of the build.
module tb_ascii_flow_splitter;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  cap_flow;
   logic [7:0]  low_flow;
   logic        is_space;
   logic [15:0] char_cnt;
   logic [15:0] drop_cnt;

   int checks = 0;
   int errors = 0;

   ascii_flow_splitter #(.DEPTH(4), .CNT_W(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .cap_flow  (cap_flow),
      .low_flow  (low_flow),
      .is_space  (is_space),
      .char_cnt  (char_cnt),
      .drop_cnt  (drop_cnt)
   );

   always #5 clk = ~clk;

   // One clock edge, then settle to the following falling edge for sampling.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      in_valid  = 1'b0;
      in_data   = 8'h00;
      out_ready = 1'b0;
      rst_n     = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
      end
      checks++;
      if (cap_flow !== 8'h00 || low_flow !== 8'h00 || is_space !== 1'b0) begin
         errors++;
         $display("FAIL reset_lanes: cap=%h low=%h sp=%b want 00 00 0", cap_flow, low_flow, is_space);
      end
      checks++;
      if (char_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_cnt: char=%0d drop=%0d want 0 0", char_cnt, drop_cnt);
      end
   endtask

   task automatic test_single();
      do_reset();
      out_ready = 1'b1;
      in_data   = 8'h49;
      in_valid  = 1'b1;
      step();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || cap_flow !== 8'h49 || low_flow !== 8'h00) begin
         errors++;
         $display("FAIL single_I: vld=%b cap=%h low=%h want 1 49 00", out_valid, cap_flow, low_flow);
      end
      step();
      checks++;
      if (char_cnt !== 16'd1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_pop: char=%0d vld=%b want 1 0", char_cnt, out_valid);
      end
   endtask

   task automatic test_stream();
      logic [7:0] s       [11] = '{8'h49, 8'h20, 8'h4C, 8'h6F, 8'h76, 8'h65, 8'h20, 8'h59, 8'h6F, 8'h75, 8'h21};
      logic [7:0] exp_cap [11] = '{8'h49, 8'h00, 8'h4C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h59, 8'h00, 8'h00, 8'h00};
      logic [7:0] exp_low [11] = '{8'h00, 8'h00, 8'h00, 8'h6F, 8'h76, 8'h65, 8'h00, 8'h00, 8'h6F, 8'h75, 8'h00};
      logic       exp_sp  [11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      logic       exp_vld [11];
      logic [15:0] exp_chars, exp_drops;
`ifdef ASCII_SPLIT_DROP_OTHER_EN
      exp_chars = 16'd10;
      exp_drops = 16'd1;
`else
      exp_chars = 16'd11;
      exp_drops = 16'd0;
`endif
      for (int i = 0; i < 11; i++) exp_vld[i] = 1'b1;
      exp_vld[10] = (exp_drops == 16'd0);

      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 11; i++) begin
         in_data  = s[i];
         in_valid = 1'b1;
         step();
         checks++;
         if (out_valid !== exp_vld[i] || cap_flow !== exp_cap[i] ||
             low_flow !== exp_low[i] || is_space !== exp_sp[i]) begin
            errors++;
            $display("FAIL stream[%0d]: vld=%b cap=%h low=%h sp=%b want %b %h %h %b", i,
                     out_valid, cap_flow, low_flow, is_space,
                     exp_vld[i], exp_cap[i], exp_low[i], exp_sp[i]);
         end
      end
      in_valid = 1'b0;
      step();
      checks++;
      if (char_cnt !== exp_chars || drop_cnt !== exp_drops || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL stream_cnt: char=%0d drop=%0d vld=%b want %0d %0d 0",
                  char_cnt, drop_cnt, out_valid, exp_chars, exp_drops);
      end
   endtask

   task automatic test_nonprint();
      logic [7:0] s       [5] = '{8'h61, 8'h0A, 8'h62, 8'h7F, 8'h63};
      logic       exp_vld [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [7:0] exp_low [5] = '{8'h61, 8'h00, 8'h62, 8'h00, 8'h63};
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_data  = s[i];
         in_valid = 1'b1;
         step();
         checks++;
         if (out_valid !== exp_vld[i] || low_flow !== exp_low[i] || cap_flow !== 8'h00) begin
            errors++;
            $display("FAIL nonprint[%0d]: vld=%b low=%h cap=%h want %b %h 00", i,
                     out_valid, low_flow, cap_flow, exp_vld[i], exp_low[i]);
         end
      end
      in_valid = 1'b0;
      step();
      checks++;
      if (drop_cnt !== 16'd2 || char_cnt !== 16'd3) begin
         errors++;
         $display("FAIL nonprint_cnt: drop=%0d char=%0d want 2 3", drop_cnt, char_cnt);
      end
   endtask

   task automatic test_full();
      logic [7:0] exp_head [4] = '{8'h42, 8'h43, 8'h44, 8'h45};
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_data  = 8'h41 + 8'(i);
         in_valid = 1'b1;
         step();
      end
      checks++;
      if (in_ready !== 1'b0 || cap_flow !== 8'h41) begin
         errors++;
         $display("FAIL full_after4: in_ready=%b cap=%h want 0 41", in_ready, cap_flow);
      end
      in_data = 8'h45;
      step();
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || cap_flow !== 8'h41) begin
         errors++;
         $display("FAIL full_hold: in_ready=%b vld=%b cap=%h want 0 1 41", in_ready, out_valid, cap_flow);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || cap_flow !== 8'h42) begin
         errors++;
         $display("FAIL full_pop1: in_ready=%b cap=%h want 1 42", in_ready, cap_flow);
      end
      step();
      in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL full_refill: in_ready=%b want 0", in_ready);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (out_valid !== 1'b1 || cap_flow !== exp_head[i]) begin
            errors++;
            $display("FAIL full_drain[%0d]: vld=%b cap=%h want 1 %h", i, out_valid, cap_flow, exp_head[i]);
         end
         step();
      end
      checks++;
      if (out_valid !== 1'b0 || char_cnt !== 16'd5) begin
         errors++;
         $display("FAIL full_end: vld=%b char=%0d want 0 5", out_valid, char_cnt);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_midreset();
      logic [7:0] s [5] = '{8'h78, 8'h01, 8'h79, 8'h7A, 8'h77};
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         in_data  = s[i];
         in_valid = 1'b1;
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      checks++;
      if (char_cnt !== 16'd1 || drop_cnt !== 16'd1 || out_valid !== 1'b1 || low_flow !== 8'h79) begin
         errors++;
         $display("FAIL midrst_pre: char=%0d drop=%0d vld=%b low=%h want 1 1 1 79",
                  char_cnt, drop_cnt, out_valid, low_flow);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || char_cnt !== 16'd0 ||
          drop_cnt !== 16'd0 || low_flow !== 8'h00) begin
         errors++;
         $display("FAIL midrst_async: vld=%b rdy=%b char=%0d drop=%0d low=%h want 0 1 0 0 00",
                  out_valid, in_ready, char_cnt, drop_cnt, low_flow);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      out_ready = 1'b1;
      in_data   = 8'h61;
      in_valid  = 1'b1;
      step();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || low_flow !== 8'h61 || cap_flow !== 8'h00) begin
         errors++;
         $display("FAIL midrst_fresh: vld=%b low=%h cap=%h want 1 61 00", out_valid, low_flow, cap_flow);
      end
      step();
      checks++;
      if (out_valid !== 1'b0 || char_cnt !== 16'd1) begin
         errors++;
         $display("FAIL midrst_after: vld=%b char=%0d want 0 1", out_valid, char_cnt);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      out_ready = 1'b0;
      test_reset();
      test_single();
      test_stream();
      test_nonprint();
      test_full();
      test_midreset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
